// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: ALU control codes, op-field values, slot layout.
package alu_pkg;

  localparam int SLOT_DW = 32;
  localparam int SLOT_AW = 5;

  localparam logic [3:0] ALU_NONE   = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0001;
  localparam logic [3:0] ALU_SUB    = 4'b0010;
  localparam logic [3:0] ALU_AND    = 4'b0011;
  localparam logic [3:0] ALU_OR     = 4'b0100;
  localparam logic [3:0] ALU_XNOR   = 4'b0101;
  localparam logic [3:0] ALU_SHIFTL = 4'b0110;
  localparam logic [3:0] ALU_SHIFTR = 4'b0111;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XNOR = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  typedef struct packed {
    logic               valid;
    logic [SLOT_DW-1:0] a;
    logic [SLOT_DW-1:0] b;
    logic [3:0]         aluctrl;
    logic [SLOT_AW-1:0] rd;
    logic [SLOT_AW-1:0] rs;
    logic [SLOT_AW-1:0] rt;
    logic               b_is_imm;
  } slot_t;

  // Register index 0 is hardwired and never bypassed; an immediate B is never replaced.
  function automatic slot_t slot_fwd(input slot_t s, input logic en,
                                     input logic [SLOT_AW-1:0] addr,
                                     input logic [SLOT_DW-1:0] data);
    slot_t r;
    r = s;
    if (en && (addr != {SLOT_AW{1'b0}})) begin
      if (s.rs == addr) begin
        r.a = data;
      end else begin
        r.a = s.a;
      end
      if (!s.b_is_imm && (s.rt == addr)) begin
        r.b = data;
      end else begin
        r.b = s.b;
      end
    end else begin
      r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational translation of the 3-bit op field into the 4-bit ALU control code.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [3:0] aluctrl
);

  always_comb begin
    aluctrl = ALU_NONE;
    case (op)
      OP_ADD:  aluctrl = ALU_ADD;
      OP_SUB:  aluctrl = ALU_SUB;
      OP_AND:  aluctrl = ALU_AND;
      OP_OR:   aluctrl = ALU_OR;
      OP_XNOR: aluctrl = ALU_XNOR;
      OP_SHL:  aluctrl = ALU_SHIFTL;
      OP_SHR:  aluctrl = ALU_SHIFTR;
      OP_NOP:  aluctrl = ALU_NONE;
      default: aluctrl = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register with a two-slot skid buffer so in_ready never depends on out_ready.
// Optional writeback bypass is enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = SLOT_DW,
  parameter int IMM_WIDTH  = 16,
  parameter int REG_AW     = SLOT_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic                  in_use_imm,
  input  logic [REG_AW-1:0]     in_rs,
  input  logic [REG_AW-1:0]     in_rt,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [3:0]            out_aluctrl,
  output logic [REG_AW-1:0]     out_rd,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  slot_t out_q, out_d, skid_q, skid_d, cap_s, out_h_s, skid_h_s;
  logic [3:0]            ctrl_s;
  logic [DATA_WIDTH-1:0] imm_ext_s;
  logic                  accept_s, drain_s;

  alu_ctrl_decode u_dec (.op(in_op), .aluctrl(ctrl_s));

  assign imm_ext_s = {{(DATA_WIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};
  assign accept_s  = in_valid & ~skid_q.valid;
  assign drain_s   = out_q.valid & out_ready;

  always_comb begin
    cap_s          = '0;
    cap_s.valid    = 1'b1;
    cap_s.a        = SLOT_DW'(in_rs_data);
    cap_s.b        = in_use_imm ? SLOT_DW'(imm_ext_s) : SLOT_DW'(in_rt_data);
    cap_s.aluctrl  = ctrl_s;
    cap_s.rd       = SLOT_AW'(in_rd);
    cap_s.b_is_imm = in_use_imm;
`ifdef ALU_ISSUE_FWD_EN
    cap_s.rs       = SLOT_AW'(in_rs);
    cap_s.rt       = SLOT_AW'(in_rt);
    cap_s          = slot_fwd(cap_s, wb_en, SLOT_AW'(wb_addr), SLOT_DW'(wb_data));
`endif
  end

`ifdef ALU_ISSUE_FWD_EN
  assign out_h_s  = out_q.valid  ? slot_fwd(out_q,  wb_en, SLOT_AW'(wb_addr), SLOT_DW'(wb_data)) : out_q;
  assign skid_h_s = skid_q.valid ? slot_fwd(skid_q, wb_en, SLOT_AW'(wb_addr), SLOT_DW'(wb_data)) : skid_q;
`else
  logic unused_s;
  assign unused_s = ^{wb_en, wb_addr, wb_data, in_rs, in_rt};
  assign out_h_s  = out_q;
  assign skid_h_s = skid_q;
`endif

  // Slot movement: flush beats everything; a drain promotes SKID or refills OUT.
  always_comb begin
    out_d  = out_h_s;
    skid_d = skid_h_s;
    if (flush) begin
      out_d  = '0;
      skid_d = '0;
    end else if (drain_s) begin
      if (skid_q.valid) begin
        out_d  = skid_h_s;
        skid_d = '0;
      end else if (accept_s) begin
        out_d = cap_s;
      end else begin
        out_d.valid = 1'b0;
      end
    end else if (accept_s) begin
      if (out_q.valid) begin
        skid_d = cap_s;
      end else begin
        out_d = cap_s;
      end
    end else begin
      out_d  = out_h_s;
      skid_d = skid_h_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready    = ~skid_q.valid;
  assign out_valid   = out_q.valid;
  assign out_a       = out_q.a[DATA_WIDTH-1:0];
  assign out_b       = out_q.b[DATA_WIDTH-1:0];
  assign out_aluctrl = out_q.aluctrl;
  assign out_rd      = out_q.rd[REG_AW-1:0];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; forwarding cases run when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

  logic        clk, rst;
  logic        in_valid, in_ready, in_use_imm, flush;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, out_rd, wb_addr;
  logic [31:0] in_rs_data, in_rt_data, out_a, out_b, wb_data;
  logic [15:0] in_imm;
  logic        out_valid, out_ready, wb_en;
  logic [3:0]  out_aluctrl;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_use_imm(in_use_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_aluctrl(out_aluctrl), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic ui,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
    in_valid = v; in_op = op; in_use_imm = ui; in_rs = rs; in_rt = rt; in_rd = rd;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_ctrl [8];

  initial begin
    exp_ctrl = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0000};
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    drive(1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
    #1 rst = 1'b1;
    step(); step();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_a", {32'd0, out_a}, 64'd0);
    check_eq("rst_out_b", {32'd0, out_b}, 64'd0);
    check_eq("rst_ctrl_rd", {55'd0, out_aluctrl, out_rd}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Basic ADD beat
    @(negedge clk);
    drive(1'b1, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    step();
    check_eq("add_valid", {63'd0, out_valid}, 64'd1);
    check_eq("add_a", {32'd0, out_a}, 64'd5);
    check_eq("add_b", {32'd0, out_b}, 64'd7);
    check_eq("add_ctrl", {60'd0, out_aluctrl}, 64'd1);
    check_eq("add_rd", {59'd0, out_rd}, 64'd3);

    // SUB with negative immediate
    @(negedge clk);
    drive(1'b1, 3'd1, 1'b1, 5'd1, 5'd2, 5'd4, 32'd100, 32'd7, 16'hFFFE);
    step();
    check_eq("imm_b", {32'd0, out_b}, 64'hFFFF_FFFE);
    check_eq("imm_a", {32'd0, out_a}, 64'd100);
    check_eq("imm_ctrl", {60'd0, out_aluctrl}, 64'd2);

    // Positive immediate stays zero-extended
    @(negedge clk);
    drive(1'b1, 3'd0, 1'b1, 5'd1, 5'd2, 5'd4, 32'd1, 32'd7, 16'h7FFF);
    step();
    check_eq("imm_pos_b", {32'd0, out_b}, 64'h0000_7FFF);

    // All ops back-to-back at full throughput
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 3'(i), 1'b0, 5'd0, 5'd0, 5'(i + 8), 32'(i), 32'd0, 16'd0);
      step();
      check_eq($sformatf("op%0d_ctrl", i), {60'd0, out_aluctrl}, {60'd0, exp_ctrl[i]});
      check_eq($sformatf("op%0d_rd", i), {58'd0, out_valid, out_rd}, {58'd0, 1'b1, 5'(i + 8)});
    end
    @(negedge clk);
    in_valid = 1'b0;
    step();
    check_eq("drain_empty", {63'd0, out_valid}, 64'd0);

    // Back-pressure: beats 1,2,3 with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd11, 32'd0, 16'd0);
    step();
    check_eq("bp1_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd22, 32'd0, 16'd0);
    step();
    check_eq("bp2_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd33, 32'd0, 16'd0);
    step();
    check_eq("bp3_hold", {27'd0, in_ready, out_valid, out_rd, out_a}, {27'd0, 1'b0, 1'b1, 5'd1, 32'd11});
    @(negedge clk);
    out_ready = 1'b1;
    step();
    check_eq("bp_out2", {26'd0, out_valid, out_rd, out_a}, {26'd0, 1'b1, 5'd2, 32'd22});
    @(negedge clk);
    step();
    check_eq("bp_out3", {26'd0, out_valid, out_rd, out_a}, {26'd0, 1'b1, 5'd3, 32'd33});
    @(negedge clk);
    in_valid = 1'b0;
    step();
    check_eq("bp_empty", {63'd0, out_valid}, 64'd0);

    // Flush from FULL with a beat offered
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'd55, 32'd0, 16'd0);
    step();
    @(negedge clk);
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd6, 32'd66, 32'd0, 16'd0);
    step();
    check_eq("fl_full", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b1});
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd7, 32'd77, 32'd0, 16'd0);
    step();
    check_eq("fl_state", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("fl_none%0d", i), {63'd0, out_valid}, 64'd0);
    end

`ifdef ALU_ISSUE_FWD_EN
    @(negedge clk);
    out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
    drive(1'b1, 3'd0, 1'b0, 5'd4, 5'd6, 5'd1, 32'd1, 32'd2, 16'd0);
    step();
    check_eq("fwd_cap_a", {32'd0, out_a}, 64'd9);
    check_eq("fwd_cap_b", {32'd0, out_b}, 64'd2);
    @(negedge clk);
    in_valid = 1'b0; wb_addr = 5'd6; wb_data = 32'd11;
    step();
    check_eq("fwd_held_b", {32'd0, out_b}, 64'd11);
    check_eq("fwd_held_v", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    out_ready = 1'b1; wb_en = 1'b0;
    step();
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd99;
    drive(1'b1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd3, 32'd4, 16'd0);
    step();
    check_eq("fwd_zero", {out_a, out_b}, {32'd3, 32'd4});
    @(negedge clk);
    wb_en = 1'b0; in_valid = 1'b0;
    step();
`endif

    // Async reset mid-cycle while FULL
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 1'b0, 5'd0, 5'd0, 5'd9, 32'd88, 32'd0, 16'd0);
    step();
    @(negedge clk);
    step();
    check_eq("ar_full", {62'd0, in_ready, out_valid}, {62'd0, 1'b0, 1'b1});
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_valid", {63'd0, out_valid}, 64'd0);
    check_eq("ar_a", {32'd0, out_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_eq("ar_ready", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue register for the pipelined datapath. It accepts decoded instructions from the decode stage over a valid/ready handshake and translates the 3-bit operation field into the 4-bit ALU control code. It selects operand B as a register value or a sign-extended immediate, and presents registered A, B, aluctrl and destination index to the execute-stage ALU. A two-entry skid buffer (output register plus skid register) keeps `in_ready` register-driven, so back-pressure never forms a combinational path upstream.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `IMM_WIDTH`, 16, immediate width, sign-extended to DATA_WIDTH
- `REG_AW`, 5, register index width
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: decode-stage instruction valid
- `in_ready` out 1: stage can accept this cycle
- `in_op` in 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XNOR, 5 SHL, 6 SHR, 7 NOP
- `in_use_imm` in 1: B = sign-extended `in_imm` instead of `in_rt_data`
- `in_rs`, `in_rt`, `in_rd` in REG_AW: source and destination indices
- `in_rs_data`, `in_rt_data` in DATA_WIDTH: register-file read data
- `in_imm` in IMM_WIDTH: immediate
- `flush` in 1: discard all held instructions
- `out_valid` out 1; `out_ready` in 1: execute-stage handshake
- `out_a`, `out_b` out DATA_WIDTH; `out_aluctrl` out 4; `out_rd` out REG_AW
- `wb_en` in 1; `wb_addr` in REG_AW; `wb_data` in DATA_WIDTH: writeback bypass port, used only with forwarding enabled

## Operation
- aluctrl mapping: op 0→4'b0001, 1→4'b0010, 2→4'b0011, 3→4'b0100, 4→4'b0101, 5→4'b0110, 6→4'b0111, 7→4'b0000. Code 0 makes the ALU output zero; NOP still flows as a valid beat.
- Immediate: sign-extend bit IMM_WIDTH-1. Operand B select happens at capture, not at output.
- State is two slots: OUT (drives outputs) and SKID. Occupancy is EMPTY, ONE (OUT valid), or FULL (OUT+SKID valid).
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- EMPTY + accept → ONE.
- ONE + accept + drain → ONE, with new data in OUT.
- ONE + accept, no drain → FULL, with new data in SKID.
- ONE + drain, no accept → EMPTY.
- FULL + drain → ONE (SKID moves to OUT). No accept is possible in FULL.
- `in_ready` = SKID empty. It is a register-derived signal, with no combinational dependence on `out_ready`.
- Order is strictly preserved; no beat is dropped or duplicated.
- `flush` clears both slots in the next cycle regardless of `in_valid`/`out_ready`. An instruction offered during a flush cycle is discarded. Flush dominates any simultaneous accept or drain.
- Once `out_valid` is high, `out_*` stay stable until a drain.

## Timing
- Reset (async, immediate): `out_valid`=0, `out_a`=0, `out_b`=0, `out_aluctrl`=0, `out_rd`=0, SKID empty, `in_ready`=1.
- Latency: an instruction accepted at edge N appears on `out_*` with `out_valid` high after edge N (1 cycle) when the stage was EMPTY, or when ONE with a simultaneous drain.
- Throughput: 1 beat/cycle with `out_ready` held high.
- `out_ready` low for k cycles from ONE: one more beat is accepted, then `in_ready` falls until the first drain.
- Reset asserted mid-transfer: all held beats are lost and outputs return to reset values asynchronously.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: at capture, if `wb_en` and `wb_addr`≠0, `wb_data` replaces `in_rs_data` when `wb_addr`==`in_rs`, and replaces `in_rt_data` when `wb_addr`==`in_rt` and `!in_use_imm`. Held OUT/SKID entries compare their stored rs/rt against `wb_addr` every cycle and update A/B in place, without disturbing `out_valid`.
- `ALU_ISSUE_FWD_EN` undefined: `wb_*` ports exist but are ignored. No rs/rt storage is required.

## Structure
- Shared package `alu_pkg`: ALU control localparams (ADD..SHIFTR, NONE=0), op-field constants, and the slot struct {valid, a, b, aluctrl, rd, rs, rt, b_is_imm}.
- One sub-module: `alu_ctrl_decode` (op→aluctrl, combinational). The slot logic stays in the top module.

## Test plan
- Reset, then op=0, rs_data=5, rt_data=7, rd=3, out_ready=1 → next cycle out_valid=1, A=5, B=7, aluctrl=0001, rd=3.
- op=1, use_imm=1, imm=16'hFFFE → B=32'hFFFF_FFFE, aluctrl=0010. op=7 → aluctrl=0000.
- out_ready=0, three back-to-back beats 1,2,3 → beats 1 and 2 held, in_ready=0, beat 3 stalled. out_ready=1 → outputs 1,2,3 in order on consecutive cycles.
- FULL state, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and no beat ever emerges.
- With FWD_EN: in_rs=4, wb_en=1, wb_addr=4, wb_data=9 at capture → A=9. Held beat with rt=6, wb_addr=6, wb_data=11 → B updates to 11 while stalled. wb_addr=0 → no bypass.
- rst asserted asynchronously mid-cycle while FULL → out_valid drops before the next edge, and in_ready=1 after release.
